control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit.sv | 107 ++++++++++
 tb/tb_control_unit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Alien attack sequencer: latches per-alien kills and steps through three attack waves.
// Optional macro CU_RESTART_EN: hold DONE for DONE_HOLD cycles, then restart at wave 1.
module control_unit #(
  parameter int unsigned DONE_HOLD = 16
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       alien1_hit,
  input  logic       alien2_hit,
  input  logic       alien3_hit,
  input  logic       alien4_hit,
  input  logic       alien5_hit,
  input  logic       alien6_hit,
  input  logic       alien7_hit,
  input  logic       alien8_hit,
  input  logic       alien9_hit,
  input  logic       alien10_hit,
  input  logic       alien11_hit,
  input  logic       alien12_hit,
  output logic [1:0] alien_control
);

  if (DONE_HOLD < 1 || DONE_HOLD > 255) begin : g_bad_hold
    $error("DONE_HOLD must be in 1..255");
  end

  typedef enum logic [2:0] {StIdle, StWave1, StWave2, StWave3, StDone} state_e;

  state_e      state_q, state_d;
  logic [11:0] dead_q, dead_d;
  logic [11:0] hits;
  logic [1:0]  ctrl_d;
  logic        g1_clear, g2_clear, g3_clear;

  assign hits = {alien12_hit, alien11_hit, alien10_hit, alien9_hit,
                 alien8_hit,  alien7_hit,  alien6_hit,  alien5_hit,
                 alien4_hit,  alien3_hit,  alien2_hit,  alien1_hit};

  // Group status comes from the registered dead bits only, never the live hits.
  assign g1_clear = &dead_q[3:0];
  assign g2_clear = &dead_q[7:4];
  assign g3_clear = &dead_q[11:8];

`ifdef CU_RESTART_EN
  logic [7:0] hold_q, hold_d;
  logic       hold_done;

  assign hold_done = (hold_q == 8'(DONE_HOLD - 1));
`endif

  always_comb begin
    state_d = state_q;
    dead_d  = dead_q | hits;
`ifdef CU_RESTART_EN
    hold_d  = 8'd0;
`endif
    unique case (state_q)
      StIdle:  state_d = StWave1;
      StWave1: if (g1_clear) state_d = StWave2;
      StWave2: if (g2_clear) state_d = StWave3;
      StWave3: if (g3_clear) state_d = StDone;
      StDone: begin
`ifdef CU_RESTART_EN
        if (hold_done) begin
          state_d = StWave1;
          dead_d  = '0;
        end else begin
          hold_d = hold_q + 8'd1;
        end
`else
        state_d = StDone;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  // Output register loads the decode of the next state so it tracks the state register.
  always_comb begin
    ctrl_d = 2'b00;
    unique case (state_d)
      StWave1: ctrl_d = 2'b01;
      StWave2: ctrl_d = 2'b10;
      StWave3: ctrl_d = 2'b11;
      default: ctrl_d = 2'b00;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= StIdle;
      dead_q        <= '0;
      alien_control <= 2'b00;
`ifdef CU_RESTART_EN
      hold_q        <= 8'd0;
`endif
    end else begin
      state_q       <= state_d;
      dead_q        <= dead_d;
      alien_control <= ctrl_d;
`ifdef CU_RESTART_EN
      hold_q        <= hold_d;
`endif
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit; restart checks apply when CU_RESTART_EN is set.
module tb_control_unit;

  logic        Clk;
  logic        Reset;
  logic [11:0] hits;
  logic [1:0]  alien_control;

  int n_checks = 0;
  int n_fail   = 0;

  control_unit #(.DONE_HOLD(4)) u_dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .alien1_hit   (hits[0]),
    .alien2_hit   (hits[1]),
    .alien3_hit   (hits[2]),
    .alien4_hit   (hits[3]),
    .alien5_hit   (hits[4]),
    .alien6_hit   (hits[5]),
    .alien7_hit   (hits[6]),
    .alien8_hit   (hits[7]),
    .alien9_hit   (hits[8]),
    .alien10_hit  (hits[9]),
    .alien11_hit  (hits[10]),
    .alien12_hit  (hits[11]),
    .alien_control(alien_control)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [1:0] got, input logic [1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", tag, got, exp);
    end
  endtask

  // One rising edge; returns on the following falling edge for stimulus and sampling.
  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    hits  = '0;
    tick();
    tick();
    Reset = 1'b0;
    tick();
  endtask

  initial begin
    logic [1:0] exp_n;
    logic [1:0] exp_n1;
    int         grp;

    Reset = 1'b1;
    hits  = '0;
    @(negedge Clk);

    // Reset behaviour and release
    tick();
    check_eq("reset_cyc1", alien_control, 2'b00);
    tick();
    check_eq("reset_cyc2", alien_control, 2'b00);
    Reset = 1'b0;
    tick();
    check_eq("release_wave1", alien_control, 2'b01);
    repeat (5) tick();
    check_eq("idle_no_hits", alien_control, 2'b01);

    // Group 1 on separate cycles, alien3 hit twice
    hits = 12'h001; tick(); hits = '0; tick();
    hits = 12'h004; tick(); hits = '0; tick();
    hits = 12'h004; tick(); hits = '0; tick();
    hits = 12'h002; tick(); hits = '0; tick();
    check_eq("g1_partial", alien_control, 2'b01);
    hits = 12'h008; tick(); hits = '0;
    check_eq("g1_last_edge_n", alien_control, 2'b01);
    tick();
    check_eq("g1_last_edge_n1", alien_control, 2'b10);

    // All aliens in order, one every 10 cycles
    do_reset();
    check_eq("seq_start", alien_control, 2'b01);
    for (int k = 0; k < 12; k++) begin
      grp    = (k + 1) / 4;
      exp_n  = 2'((k / 4) + 1);
      exp_n1 = (grp == 3) ? 2'b00 : 2'(grp + 1);
      hits   = 12'(1) << k;
      tick();
      hits = '0;
      check_eq($sformatf("seq_hit%0d_n", k + 1), alien_control, exp_n);
      tick();
      check_eq($sformatf("seq_hit%0d_n1", k + 1), alien_control, exp_n1);
      if (k != 11) repeat (8) tick();
    end
`ifdef CU_RESTART_EN
    repeat (3) begin
      tick();
      check_eq("done_hold", alien_control, 2'b00);
    end
    tick();
    check_eq("restart_wave1", alien_control, 2'b01);
    repeat (10) tick();
    check_eq("restart_dead_cleared", alien_control, 2'b01);
`else
    repeat (30) tick();
    check_eq("done_terminal", alien_control, 2'b00);
`endif

    // Later groups first, then group 1 in one cycle: no wave skipped
    do_reset();
    for (int k = 4; k < 12; k++) begin
      hits = 12'(1) << k;
      tick();
    end
    hits = '0;
    tick();
    check_eq("out_of_order_hold", alien_control, 2'b01);
    hits = 12'h00F;
    tick();
    hits = '0;
    check_eq("burst_n", alien_control, 2'b01);
    tick();
    check_eq("burst_n1", alien_control, 2'b10);
    tick();
    check_eq("burst_n2", alien_control, 2'b11);
    tick();
    check_eq("burst_n3", alien_control, 2'b00);

    // Reset in wave 3 discards progress; hits during reset are ignored
    do_reset();
    hits = 12'h0FF;
    tick();
    hits = '0;
    tick();
    tick();
    check_eq("reach_wave3", alien_control, 2'b11);
    Reset = 1'b1;
    hits  = 12'hF00;
    tick();
    check_eq("reset_mid_wave", alien_control, 2'b00);
    Reset = 1'b0;
    hits  = '0;
    tick();
    check_eq("reset_release", alien_control, 2'b01);
    repeat (5) tick();
    check_eq("dead_cleared", alien_control, 2'b01);
    hits = 12'h0FF;
    tick();
    hits = '0;
    tick();
    tick();
    check_eq("rewave3", alien_control, 2'b11);
    repeat (4) tick();
    check_eq("reset_hits_ignored", alien_control, 2'b11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
